// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encoding and the
// per-cycle control bundle that drives the pipeline registers and the PC.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic idex_write;
    logic exmem_hold;
    logic memwb_bubble;
    logic dmem_req;
  } ctrl_t;

  // Everything advances, nothing is squashed.
  function automatic ctrl_t ctrl_default(input logic req);
    ctrl_t c;
    c            = '0;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    c.idex_write = 1'b1;
    c.dmem_req   = req;
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c              = '0;
    c.ifid_flush   = 1'b1;
    c.idex_bubble  = 1'b1;
    c.memwb_bubble = 1'b1;
    return c;
  endfunction

  // Front of the pipe frozen, EX/MEM held, MEM/WB fed bubbles while memory is busy.
  function automatic ctrl_t ctrl_mem_stall();
    ctrl_t c;
    c              = '0;
    c.exmem_hold   = 1'b1;
    c.memwb_bubble = 1'b1;
    c.dmem_req     = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_load_use(input logic req);
    ctrl_t c;
    c             = ctrl_default(req);
    c.pc_write    = 1'b0;
    c.ifid_write  = 1'b0;
    c.idex_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: the ID/EX load writes a register the IF/ID instruction reads.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs1_i,
  input  logic [REG_AW-1:0] ifid_rs2_i,
  input  logic              ifid_rs1_used_i,
  input  logic              ifid_rs2_used_i,
  output logic              lu_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  assign rs1_hit = ifid_rs1_used_i && (ifid_rs1_i == idex_rd_i);
  assign rs2_hit = ifid_rs2_used_i && (ifid_rs2_i == idex_rd_i);
  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign rd_live = (idex_rd_i != '0);

  assign lu_o = idex_memread_i && rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush/bubble decode for load-use,
// taken branches and variable-latency data memory, plus stall counter and timeout flag.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs1_i,
  input  logic [REG_AW-1:0] ifid_rs2_i,
  input  logic              ifid_rs1_used_i,
  input  logic              ifid_rs2_used_i,
  input  logic              branch_taken_i,
  input  logic              exmem_memread_i,
  input  logic              exmem_memwrite_i,
  input  logic              dmem_ack_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              idex_write_o,
  output logic              exmem_hold_o,
  output logic              memwb_bubble_o,
  output logic              dmem_req_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              err_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d;

  logic  acc;
  logic  lu;
  logic  mem_stall;
  ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .idex_memread_i  (idex_memread_i),
    .idex_rd_i       (idex_rd_i),
    .ifid_rs1_i      (ifid_rs1_i),
    .ifid_rs2_i      (ifid_rs2_i),
    .ifid_rs1_used_i (ifid_rs1_used_i),
    .ifid_rs2_used_i (ifid_rs2_used_i),
    .lu_o            (lu)
  );

  assign acc = exmem_memread_i | exmem_memwrite_i;

  // A missing ack stalls from the very first cycle of the access, even while still in RUN.
  assign mem_stall = (state_q == ST_MEM_WAIT) ? !dmem_ack_i : (acc && !dmem_ack_i);

  always_comb begin : decode
    ctrl = ctrl_default(1'b0);
    if (rst_i) begin
      ctrl = ctrl_reset();
    end else if (mem_stall) begin
      ctrl = ctrl_mem_stall();
    end else if (state_q == ST_MEM_WAIT) begin
      ctrl = ctrl_default(1'b1);
    end else if (lu) begin
      ctrl = ctrl_load_use(acc);
    end else begin
      ctrl            = ctrl_default(acc);
      ctrl.ifid_flush = branch_taken_i;
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;

    if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (acc && !dmem_ack_i) begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        if (wait_cnt_q == WAIT_LAST) begin
          err_d = 1'b1;
        end
        if (dmem_ack_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pc_write_o     = ctrl.pc_write;
  assign ifid_write_o   = ctrl.ifid_write;
  assign ifid_flush_o   = ctrl.ifid_flush;
  assign idex_bubble_o  = ctrl.idex_bubble;
  assign idex_write_o   = ctrl.idex_write;
  assign exmem_hold_o   = ctrl.exmem_hold;
  assign memwb_bubble_o = ctrl.memwb_bubble;
  assign dmem_req_o     = ctrl.dmem_req;
  assign stall_cnt_o    = stall_cnt_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expected controls from a small
// reference model, plus directed checks on stall count and timeout flag.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO    = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          idex_memread_i = 1'b0;
  logic [4:0]    idex_rd_i = '0;
  logic [4:0]    ifid_rs1_i = '0;
  logic [4:0]    ifid_rs2_i = '0;
  logic          ifid_rs1_used_i = 1'b0;
  logic          ifid_rs2_used_i = 1'b0;
  logic          branch_taken_i = 1'b0;
  logic          exmem_memread_i = 1'b0;
  logic          exmem_memwrite_i = 1'b0;
  logic          dmem_ack_i = 1'b0;
  logic          pc_write_o;
  logic          ifid_write_o;
  logic          ifid_flush_o;
  logic          idex_bubble_o;
  logic          idex_write_o;
  logic          exmem_hold_o;
  logic          memwb_bubble_o;
  logic          dmem_req_o;
  logic [CW-1:0] stall_cnt_o;
  logic          err_o;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .idex_memread_i   (idex_memread_i),
    .idex_rd_i        (idex_rd_i),
    .ifid_rs1_i       (ifid_rs1_i),
    .ifid_rs2_i       (ifid_rs2_i),
    .ifid_rs1_used_i  (ifid_rs1_used_i),
    .ifid_rs2_used_i  (ifid_rs2_used_i),
    .branch_taken_i   (branch_taken_i),
    .exmem_memread_i  (exmem_memread_i),
    .exmem_memwrite_i (exmem_memwrite_i),
    .dmem_ack_i       (dmem_ack_i),
    .pc_write_o       (pc_write_o),
    .ifid_write_o     (ifid_write_o),
    .ifid_flush_o     (ifid_flush_o),
    .idex_bubble_o    (idex_bubble_o),
    .idex_write_o     (idex_write_o),
    .exmem_hold_o     (exmem_hold_o),
    .memwb_bubble_o   (memwb_bubble_o),
    .dmem_req_o       (dmem_req_o),
    .stall_cnt_o      (stall_cnt_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       rst;
    logic       ldr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       br;
    logic       mr;
    logic       mw;
    logic       ack;
  } stim_t;

  // ctrl bit order: pc_write ifid_write ifid_flush idex_bubble idex_write exmem_hold memwb_bubble dmem_req
  typedef struct packed {
    logic [7:0]    ctrl;
    logic [CW-1:0] cnt;
    logic          err;
    logic          known;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic        m_wait_st = 1'b0;
  int unsigned m_wait    = 0;
  int unsigned m_cnt     = 0;
  logic        m_err     = 1'b0;
  logic        m_known   = 1'b0;

  stim_t s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input stim_t st);
    logic       acc, lu, stall;
    logic [7:0] c;
    exp_t       e, got_e;
    @(negedge clk_i);
    rst_i            = st.rst;
    idex_memread_i   = st.ldr;
    idex_rd_i        = st.rd;
    ifid_rs1_i       = st.rs1;
    ifid_rs2_i       = st.rs2;
    ifid_rs1_used_i  = st.u1;
    ifid_rs2_used_i  = st.u2;
    branch_taken_i   = st.br;
    exmem_memread_i  = st.mr;
    exmem_memwrite_i = st.mw;
    dmem_ack_i       = st.ack;

    acc   = st.mr | st.mw;
    lu    = st.ldr && (st.rd != 0) &&
            ((st.u1 && st.rs1 == st.rd) || (st.u2 && st.rs2 == st.rd));
    stall = m_wait_st ? !st.ack : (acc && !st.ack);
    if (st.rst)          c = 8'b0011_0010;
    else if (stall)      c = 8'b0000_0111;
    else if (m_wait_st)  c = 8'b1100_1001;
    else if (lu)         c = {5'b00011, 2'b00, acc};
    else if (st.br)      c = {5'b11101, 2'b00, acc};
    else                 c = {5'b11001, 2'b00, acc};

    e.ctrl  = c;
    e.cnt   = CW'(m_cnt);
    e.err   = m_err;
    e.known = m_known;
    sb_q.push_back(e);

    #1;
    got_e = sb_q.pop_front();
    chk("ctrl", {24'h0, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
                 idex_write_o, exmem_hold_o, memwb_bubble_o, dmem_req_o}, {24'h0, got_e.ctrl});
    if (got_e.known) begin
      chk("stall_cnt", 32'(stall_cnt_o), 32'(got_e.cnt));
      chk("err", 32'(err_o), 32'(got_e.err));
    end

    if (st.rst) begin
      m_wait_st = 1'b0;
      m_wait    = 0;
      m_cnt     = 0;
      m_err     = 1'b0;
      m_known   = 1'b1;
    end else begin
      if (!c[7] && m_cnt < CMAX) m_cnt++;
      if (!m_wait_st) begin
        m_wait = 0;
        if (acc && !st.ack) m_wait_st = 1'b1;
      end else begin
        if (m_wait < TO) m_wait++;
        if (m_wait == TO) m_err = 1'b1;
        if (st.ack) m_wait_st = 1'b0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // reset then idle
    s = '0; s.rst = 1'b1;
    repeat (2) step(s);
    s = '0;
    repeat (2) step(s);
    chk("t1_cnt", 32'(stall_cnt_o), 32'd0);

    // load-use on rs2, then rd=0, then unused rs1 match
    s = '0; s.ldr = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
    step(s);
    chk("t2_cnt", 32'(stall_cnt_o), 32'd1);
    s = '0; s.ldr = 1'b1; s.rd = 5'd0; s.rs2 = 5'd0; s.u2 = 1'b1;
    step(s);
    s = '0; s.ldr = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b0;
    step(s);
    chk("t2_rd0_cnt", 32'(stall_cnt_o), 32'd1);

    // load with ack on the fourth cycle
    s = '0; s.mr = 1'b1;
    repeat (3) step(s);
    s.ack = 1'b1;
    step(s);
    s = '0;
    step(s);
    chk("t3_cnt", 32'(stall_cnt_o), 32'd4);

    // load-use wins over branch, branch flushes next cycle
    s = '0; s.ldr = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1; s.br = 1'b1;
    step(s);
    s.ldr = 1'b0;
    step(s);
    s = '0;
    step(s);
    chk("t4_cnt", 32'(stall_cnt_o), 32'd5);

    // store never acked: timeout, sticky flag, counter saturation, reset abandons
    s = '0; s.mw = 1'b1;
    repeat (5) step(s);
    chk("t5_err", 32'(err_o), 32'd1);
    repeat (30) step(s);
    chk("t5_err_sticky", 32'(err_o), 32'd1);
    chk("t5_sat", 32'(stall_cnt_o), CMAX);
    s.rst = 1'b1;
    step(s);
    chk("t5_rst_err", 32'(err_o), 32'd0);
    chk("t5_rst_cnt", 32'(stall_cnt_o), 32'd0);
    s = '0;
    step(s);

    // stray ack in RUN, then zero-wait store
    s = '0; s.ack = 1'b1;
    step(s);
    s.ack = 1'b0;
    step(s);
    s = '0; s.mw = 1'b1; s.ack = 1'b1;
    step(s);
    s = '0;
    step(s);
    chk("t6_cnt", 32'(stall_cnt_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
